hqm_qed_rf_pg_fifo_ctl: RTL and testbench
=========================================

# hqm_qed_rf_pg_fifo_ctl

Client-side controller for a 4-entry x 45-bit power-gated two-port register file in the QED memory subsystem. It drives the RF write and read ports and its power/isolation pins, and presents a push/pop FIFO with full throughput to the pipeline. Power-up and power-down are sequenced against the RF power-enable daisy-chain. Power-down is only honoured when the FIFO holds no data.

## Interface
- DEPTH, 4, RF entries; must be a power of 2.
- DWIDTH, 45, data width.
- AWIDTH, 2, log2(DEPTH).
- clk  in  1  single clock; all RF ports are driven from it.
- rst_n  in  1  asynchronous, active-low reset.
- pwr_req_on  in  1  level request from PM: 1 = RF powered, 0 = gate it.
- pwr_on  out  1  1 only in state ON.
- push  in  1  write request; accepted only when push_rdy=1.
- push_data  in  DWIDTH  write data.
- push_rdy  out  1  ON and mem_cnt<DEPTH.
- pop_v  out  1  head-of-FIFO valid.
- pop_data  out  DWIDTH  head data.
- pop_taken  in  1  consumer takes the head this cycle; ignored when pop_v=0.
- cnt  out  AWIDTH+2  total occupancy: RF entries + in-flight read + output buffer, 0..DEPTH+2.
- err_push_drop  out  1  sticky flag, set on push with push_rdy=0; cleared only by reset.
- rf_we, rf_waddr[AWIDTH], rf_wdata[DWIDTH]  out  RF write port.
- rf_re, rf_raddr[AWIDTH]  out  RF read port.
- rf_rdata  in  DWIDTH  RF read data, valid exactly 1 cycle after rf_re.
- rf_pwr_enable_b_in  out  1  RF power enable, active-low.
- rf_pwr_enable_b_out  in  1  RF power-chain acknowledge, active-low.
- rf_pgcb_isol_en  out  1  RF output isolation, 1 = isolated.

## Operation
- RF write side:
  - rf_we = push & push_rdy; rf_waddr = wptr; rf_wdata = push_data.
  - wptr increments mod DEPTH on each write.
- mem_cnt counts entries written to the RF but not yet read.
  - +1 on write, -1 on rf_re, both in the same cycle allowed.
  - An entry is readable the cycle after its write, so the RF never sees a same-cycle read and write of one address.
- Read side:
  - Output buffer is a 2-entry skid FIFO (obuf_cnt 0..2).
  - rd_inflight = rf_re registered; it marks that rf_rdata is valid this cycle.
  - rf_re = ON & mem_cnt>0 & (obuf_cnt + rd_inflight - (pop_taken&pop_v)) < 2.
  - rf_raddr = rptr; rptr increments mod DEPTH on each rf_re.
  - When rd_inflight=1, rf_rdata is written into the obuf tail.
  - pop_v = obuf_cnt>0; pop_data = obuf head.
- Power FSM:
  - OFF: rf_pwr_enable_b_in=1, rf_pgcb_isol_en=1. Go to PUP when pwr_req_on=1.
  - PUP: rf_pwr_enable_b_in=0, isol=1. Go to DEISO when rf_pwr_enable_b_out=0.
  - DEISO: rf_pwr_enable_b_in=0, isol=1 for exactly one cycle, then go to ON.
  - ON: enable_b_in=0, isol=0.
    - Go to PDN when pwr_req_on=0 & cnt=0.
    - If pwr_req_on=0 with cnt>0, stay in ON. Pushes stay blocked only when full, and the FIFO keeps draining.
  - PDN: isol=1, enable_b_in=0 for one cycle, then go to WAIT_OFF.
  - WAIT_OFF: enable_b_in=1, isol=1. Go to OFF when rf_pwr_enable_b_out=1.
  - In PUP, if pwr_req_on drops, keep going. The sequence completes to ON, and ON then handles the power-down.
- No rf_we or rf_re is issued outside ON.

## Timing
- Reset values:
  - State OFF.
  - rf_pwr_enable_b_in=1, rf_pgcb_isol_en=1.
  - rf_we=0, rf_re=0, rf_waddr=0, rf_raddr=0, rf_wdata=0.
  - pop_v=0, pop_data=0, push_rdy=0, pwr_on=0, cnt=0, err_push_drop=0.
  - wptr=0, rptr=0, mem_cnt=0, obuf_cnt=0, rd_inflight=0.
- Latency with an empty FIFO:
  - push at cycle N.
  - rf_re at N+1.
  - rf_rdata at N+2.
  - pop_v=1 at N+3.
- Throughput: one push and one pop per cycle sustained.
- Power-up: pwr_req_on rises at N; PUP at N+1. If ack arrives at M, DEISO at M+1 and ON (pwr_on=1) at M+2.
- Wrap-around: the pointers roll 3→0 with no bubble.
- Reset during any state returns to OFF immediately and discards all contents.

## Test plan
- Power-up:
  - Stimulus: raise pwr_req_on; ack rf_pwr_enable_b_out=0 three cycles later.
  - Required: isol falls exactly 2 cycles after the ack, and pwr_on=1 in that same cycle.
- Single push with an idle consumer:
  - Stimulus: push 45'h1_2345_6789_A.
  - Required: pop_v=1 three cycles later with that data.
  - Required: cnt goes 0→1 and stays 1 until pop_taken.
- Fill to capacity with pop_taken=0:
  - Stimulus: push values 0..7.
  - Required: values 0..5 are accepted and cnt=6. The FIFO stalls at mem_cnt=4 (RF full) with push_rdy=0, and the 7th push sets err_push_drop.
  - Required: draining gives 0..5 in order.
- Streaming:
  - Stimulus: push and pop_taken=1 every cycle for 20 values.
  - Required: in-order output, no bubble after the first pop_v, and pointers wrap 5 times.
- Deferred power-down:
  - Stimulus: pwr_req_on=0 with cnt=3.
  - Required: stays in ON. Once the last pop empties the FIFO, PDN follows next cycle, then WAIT_OFF, then OFF after ack=1.
- Reset mid-stream:
  - Stimulus: assert rst_n low with cnt=4.
  - Required: all outputs take their reset values asynchronously; after reset release, push_rdy=0 until power-up completes.

Source files
------------

// File: rtl/hqm_qed_rf_pg_fifo_ctl.sv
// hqm_qed_rf_pg_fifo_ctl
// Push/pop FIFO front-end for a power-gated two-port register file. Entries
// are stored in the RF. A 2-deep skid buffer behind the RF read port hides
// the 1-cycle read latency, so the consumer gets one pop per cycle. The power
// FSM walks the RF power-enable daisy-chain and only gates the array once the
// FIFO is completely empty.
module hqm_qed_rf_pg_fifo_ctl #(
    parameter int DEPTH  = 4,
    parameter int DWIDTH = 45,
    parameter int AWIDTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwr_req_on,
    output logic              pwr_on,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    output logic              push_rdy,
    output logic              pop_v,
    output logic [DWIDTH-1:0] pop_data,
    input  logic              pop_taken,
    output logic [AWIDTH+1:0] cnt,
    output logic              err_push_drop,
    output logic              rf_we,
    output logic [AWIDTH-1:0] rf_waddr,
    output logic [DWIDTH-1:0] rf_wdata,
    output logic              rf_re,
    output logic [AWIDTH-1:0] rf_raddr,
    input  logic [DWIDTH-1:0] rf_rdata,
    output logic              rf_pwr_enable_b_in,
    input  logic              rf_pwr_enable_b_out,
    output logic              rf_pgcb_isol_en
);

    localparam logic [AWIDTH:0] MEM_FULL = (AWIDTH+1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PUP,
        ST_DEISO,
        ST_ON,
        ST_PDN,
        ST_WAIT_OFF
    } pwr_state_e;

    pwr_state_e        state, state_nxt;
    logic              on;

    logic [AWIDTH-1:0] wptr, rptr;
    logic [AWIDTH:0]   mem_cnt;      // written to the RF, not yet read
    logic              rd_inflight;  // rf_rdata is valid this cycle

    logic [1:0]        obuf_cnt;
    logic              obuf_hd, obuf_tl;
    logic [DWIDTH-1:0] obuf_data [2];

    logic              pop;
    logic [2:0]        rd_occ;

    assign on  = (state == ST_ON);
    assign pop = pop_taken & pop_v;

    // Write side: accept whenever powered and the RF has a free slot
    assign push_rdy = on && (mem_cnt < MEM_FULL);
    assign rf_we    = push & push_rdy;
    assign rf_waddr = wptr;
    assign rf_wdata = rf_we ? push_data : '0;

    // Read side: issue a read only if the skid buffer still has room once the
    // read in flight lands and this cycle's pop leaves. Comparing against
    // 2+pop keeps the arithmetic unsigned.
    assign rd_occ   = 3'(obuf_cnt) + 3'(rd_inflight);
    assign rf_re    = on && (mem_cnt != '0) && (rd_occ < (3'd2 + 3'(pop)));
    assign rf_raddr = rptr;

    assign pop_v    = (obuf_cnt != 2'd0);
    assign pop_data = obuf_data[obuf_hd];

    assign cnt = (AWIDTH+2)'(mem_cnt) + (AWIDTH+2)'(rd_inflight) + (AWIDTH+2)'(obuf_cnt);

    // RF pointers, occupancy and read-valid pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            mem_cnt     <= '0;
            rd_inflight <= 1'b0;
        end else begin
            if (rf_we) wptr <= wptr + 1'b1;
            if (rf_re) rptr <= rptr + 1'b1;
            case ({rf_we, rf_re})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
            rd_inflight <= rf_re;
        end
    end

    // Skid buffer: RF read data lands at the tail, the consumer pops the head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obuf_cnt <= 2'd0;
            obuf_hd  <= 1'b0;
            obuf_tl  <= 1'b0;
            for (int i = 0; i < 2; i++) obuf_data[i] <= '0;
        end else begin
            if (rd_inflight) begin
                obuf_data[obuf_tl] <= rf_rdata;
                obuf_tl            <= ~obuf_tl;
            end
            if (pop) obuf_hd <= ~obuf_hd;
            obuf_cnt <= obuf_cnt + 2'(rd_inflight) - 2'(pop);
        end
    end

    // Sticky drop flag: a push the FIFO could not take
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_push_drop <= 1'b0;
        else if (push && !push_rdy) err_push_drop <= 1'b1;
    end

    // Power FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_OFF;
        else        state <= state_nxt;
    end

    // Power FSM next state and power/isolation pins
    always_comb begin
        state_nxt          = state;
        pwr_on             = 1'b0;
        rf_pwr_enable_b_in = 1'b1;
        rf_pgcb_isol_en    = 1'b1;
        case (state)
            ST_OFF: begin
                if (pwr_req_on) state_nxt = ST_PUP;
            end
            ST_PUP: begin
                // A dropped request is ignored here; ON handles the power-down
                rf_pwr_enable_b_in = 1'b0;
                if (!rf_pwr_enable_b_out) state_nxt = ST_DEISO;
            end
            ST_DEISO: begin
                rf_pwr_enable_b_in = 1'b0;
                state_nxt          = ST_ON;
            end
            ST_ON: begin
                pwr_on             = 1'b1;
                rf_pwr_enable_b_in = 1'b0;
                rf_pgcb_isol_en    = 1'b0;
                // A write landing this cycle would be lost, so it holds us in ON
                if (!pwr_req_on && (cnt == '0) && !rf_we) state_nxt = ST_PDN;
            end
            ST_PDN: begin
                rf_pwr_enable_b_in = 1'b0;
                state_nxt          = ST_WAIT_OFF;
            end
            ST_WAIT_OFF: begin
                if (rf_pwr_enable_b_out) state_nxt = ST_OFF;
            end
            default: begin
                state_nxt = ST_OFF;
            end
        endcase
    end

endmodule

// File: tb/tb_hqm_qed_rf_pg_fifo_ctl.sv
// Self-checking bench for hqm_qed_rf_pg_fifo_ctl. The expected behaviour comes
// from a queue of {data, push cycle}: an entry is visible 3 cycles after its
// push, the read stage holds at most two entries, and the power sequence
// follows the power-enable chain handshake.
module tb_hqm_qed_rf_pg_fifo_ctl;
    localparam int DEPTH  = 4;
    localparam int DWIDTH = 45;
    localparam int AWIDTH = 2;

    localparam int S_OFF = 0, S_PUP = 1, S_DEISO = 2, S_ON = 3, S_PDN = 4, S_WAIT = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pwr_req_on = 1'b0;
    logic              push = 1'b0;
    logic [DWIDTH-1:0] push_data = '0;
    logic              pop_taken = 1'b0;
    logic              rf_pwr_enable_b_out = 1'b1;
    logic [DWIDTH-1:0] rf_rdata = '0;

    logic              pwr_on, push_rdy, pop_v, err_push_drop;
    logic [DWIDTH-1:0] pop_data, rf_wdata;
    logic [AWIDTH+1:0] cnt;
    logic              rf_we, rf_re, rf_pwr_enable_b_in, rf_pgcb_isol_en;
    logic [AWIDTH-1:0] rf_waddr, rf_raddr;

    logic [DWIDTH-1:0] rf_mem [DEPTH];

    always #5 clk = ~clk;

    hqm_qed_rf_pg_fifo_ctl #(.DEPTH(DEPTH), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pwr_req_on          (pwr_req_on),
        .pwr_on              (pwr_on),
        .push                (push),
        .push_data           (push_data),
        .push_rdy            (push_rdy),
        .pop_v               (pop_v),
        .pop_data            (pop_data),
        .pop_taken           (pop_taken),
        .cnt                 (cnt),
        .err_push_drop       (err_push_drop),
        .rf_we               (rf_we),
        .rf_waddr            (rf_waddr),
        .rf_wdata            (rf_wdata),
        .rf_re               (rf_re),
        .rf_raddr            (rf_raddr),
        .rf_rdata            (rf_rdata),
        .rf_pwr_enable_b_in  (rf_pwr_enable_b_in),
        .rf_pwr_enable_b_out (rf_pwr_enable_b_out),
        .rf_pgcb_isol_en     (rf_pgcb_isol_en)
    );

    // Register file: synchronous write, read data one cycle after rf_re
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
        if (rf_re) rf_rdata <= rf_mem[rf_raddr];
    end

    typedef struct {
        logic [DWIDTH-1:0] d;
        int                pc;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;
    int   wr_total = 0;
    int   pop_total = 0;
    int   ps = S_OFF;
    bit   err_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance
    task automatic step();
        int e, r, mem, nps;
        bit on, rdy, pv, acc, pp, re;
        @(negedge clk);
        on  = (ps == S_ON);
        e   = 0;
        foreach (q[i]) if (q[i].pc <= cyc - 2) e++;
        r   = (e < 2) ? e : 2;
        mem = q.size() - r;
        rdy = on && (mem < DEPTH);
        pv  = (q.size() > 0) && (q[0].pc <= cyc - 3);
        acc = push && rdy;
        pp  = pop_taken && pv;
        re  = on && (mem > 0) && ((r - int'(pp)) < 2);

        chk("pwr_on",   64'(pwr_on), 64'(on));
        chk("en_b_in",  64'(rf_pwr_enable_b_in), 64'(!(ps inside {S_PUP, S_DEISO, S_ON, S_PDN})));
        chk("isol",     64'(rf_pgcb_isol_en), 64'(ps != S_ON));
        chk("push_rdy", 64'(push_rdy), 64'(rdy));
        chk("pop_v",    64'(pop_v), 64'(pv));
        if (pv) chk("pop_data", 64'(pop_data), 64'(q[0].d));
        chk("cnt",      64'(cnt), 64'(q.size()));
        chk("err",      64'(err_push_drop), 64'(err_m));
        chk("rf_we",    64'(rf_we), 64'(acc));
        if (acc) begin
            chk("waddr", 64'(rf_waddr), 64'(wr_total % DEPTH));
            chk("wdata", 64'(rf_wdata), 64'(push_data));
        end
        chk("rf_re",    64'(rf_re), 64'(re));
        if (re) chk("raddr", 64'(rf_raddr), 64'((pop_total + r) % DEPTH));

        nps = ps;
        case (ps)
            S_OFF:   if (pwr_req_on) nps = S_PUP;
            S_PUP:   if (!rf_pwr_enable_b_out) nps = S_DEISO;
            S_DEISO: nps = S_ON;
            S_ON:    if (!pwr_req_on && q.size() == 0) nps = S_PDN;
            S_PDN:   nps = S_WAIT;
            S_WAIT:  if (rf_pwr_enable_b_out) nps = S_OFF;
            default: nps = S_OFF;
        endcase

        @(posedge clk);
        if (pp) begin
            void'(q.pop_front());
            pop_total++;
        end
        if (acc) begin
            q.push_back('{d: push_data, pc: cyc});
            wr_total++;
        end
        if (push && !rdy) err_m = 1'b1;
        ps = nps;
        cyc++;
        #1;
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_pwr_on"},   64'(pwr_on), 64'(0));
        chk({pfx, "_en_b_in"},  64'(rf_pwr_enable_b_in), 64'(1));
        chk({pfx, "_isol"},     64'(rf_pgcb_isol_en), 64'(1));
        chk({pfx, "_rf_we"},    64'(rf_we), 64'(0));
        chk({pfx, "_rf_re"},    64'(rf_re), 64'(0));
        chk({pfx, "_waddr"},    64'(rf_waddr), 64'(0));
        chk({pfx, "_raddr"},    64'(rf_raddr), 64'(0));
        chk({pfx, "_wdata"},    64'(rf_wdata), 64'(0));
        chk({pfx, "_pop_v"},    64'(pop_v), 64'(0));
        chk({pfx, "_pop_data"}, 64'(pop_data), 64'(0));
        chk({pfx, "_push_rdy"}, 64'(push_rdy), 64'(0));
        chk({pfx, "_cnt"},      64'(cnt), 64'(0));
        chk({pfx, "_err"},      64'(err_push_drop), 64'(0));
    endtask

    // Request power, ack three cycles later, expect ON two cycles after the ack
    task automatic power_up();
        pwr_req_on = 1'b1;
        step();                        // N
        step();                        // N+1
        step();                        // N+2
        rf_pwr_enable_b_out = 1'b0;
        step();                        // M = N+3
        chk("pup_isol_m1", 64'(rf_pgcb_isol_en), 64'(1));
        chk("pup_on_m1",   64'(pwr_on), 64'(0));
        step();                        // M+1
        chk("pup_isol_m2", 64'(rf_pgcb_isol_en), 64'(0));
        chk("pup_on_m2",   64'(pwr_on), 64'(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset state
        #3;
        reset_checks("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        power_up();

        // Single push, idle consumer
        push = 1'b1;
        push_data = 45'h1_2345_6789_A;
        step();
        push = 1'b0;
        idle(2);
        chk("single_pop_v", 64'(pop_v), 64'(1));
        chk("single_data",  64'(pop_data), 64'(45'h1_2345_6789_A));
        chk("single_cnt",   64'(cnt), 64'(1));
        idle(3);
        pop_taken = 1'b1;
        step();
        pop_taken = 1'b0;
        idle(2);

        // Fill to capacity with the consumer stalled
        for (int v = 0; v < 8; v++) begin
            push = 1'b1;
            push_data = DWIDTH'(v);
            step();
        end
        push = 1'b0;
        idle(3);
        chk("fill_cnt",      64'(cnt), 64'(6));
        chk("fill_push_rdy", 64'(push_rdy), 64'(0));
        chk("fill_err",      64'(err_push_drop), 64'(1));
        chk("fill_head",     64'(pop_data), 64'(0));
        pop_taken = 1'b1;
        idle(8);
        chk("drain_cnt", 64'(cnt), 64'(0));

        // Streaming: push and pop every cycle
        for (int i = 0; i < 20; i++) begin
            push = 1'b1;
            push_data = DWIDTH'(100 + i);
            step();
        end
        push = 1'b0;
        idle(5);
        chk("stream_wraps", 64'(wr_total), 64'(6 + 20 + 1));
        chk("stream_cnt",   64'(cnt), 64'(0));

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            push = ($urandom_range(0, 9) < 7);
            push_data = DWIDTH'({$urandom(), $urandom()});
            pop_taken = ($urandom_range(0, 9) < 6);
            step();
        end
        push = 1'b0;
        pop_taken = 1'b1;
        idle(8);

        // Deferred power-down: request drops while three entries are held
        pop_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1;
            push_data = DWIDTH'(200 + i);
            step();
        end
        push = 1'b0;
        idle(3);
        chk("pdn_cnt3", 64'(cnt), 64'(3));
        pwr_req_on = 1'b0;
        idle(4);
        chk("pdn_hold_on", 64'(pwr_on), 64'(1));
        pop_taken = 1'b1;
        idle(6);
        pop_taken = 1'b0;
        chk("pdn_wait_isol", 64'(rf_pgcb_isol_en), 64'(1));
        chk("pdn_wait_en_b", 64'(rf_pwr_enable_b_in), 64'(1));
        rf_pwr_enable_b_out = 1'b1;
        idle(3);
        chk("pdn_off", 64'(pwr_on), 64'(0));

        // Reset mid-stream with four entries held
        power_up();
        for (int i = 0; i < 4; i++) begin
            push = 1'b1;
            push_data = DWIDTH'(300 + i);
            step();
        end
        push = 1'b0;
        idle(3);
        chk("mid_cnt4", 64'(cnt), 64'(4));
        #2;
        rst_n = 1'b0;
        pwr_req_on = 1'b0;
        rf_pwr_enable_b_out = 1'b1;
        #1;
        reset_checks("rst_mid");
        q.delete();
        wr_total = 0;
        pop_total = 0;
        err_m = 1'b0;
        ps = S_OFF;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        idle(3);
        power_up();
        push = 1'b1;
        push_data = 45'h0_0BAD_F00D_5;
        step();
        push = 1'b0;
        pop_taken = 1'b1;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
